// File: rtl/wb_mem_arb_pkg.sv
// Shared types for the Wishbone / stream SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, MEM, RESP} arb_state_t;
   typedef enum logic {OWNER_WB, OWNER_STR} owner_t;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

endpackage

// File: rtl/wb_mem_arb_grant.sv
// Grant decision between Wishbone and stream requesters, with stream burst limit.
// Latency: grant is combinational in the evaluate cycle; history registers update at its edge.
// Backpressure: a waiting WB master wins after STREAM_BURST_MAX back-to-back stream grants.
module wb_mem_arb_grant
   import wb_mem_arb_pkg::*;
#(
   parameter int STREAM_BURST_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic eval,
   input  logic wb_req,
   input  logic str_req,
   output logic gnt_wb,
   output logic gnt_str
);

   localparam logic [3:0] BURST_MAX = 4'(STREAM_BURST_MAX);

   logic [3:0] burst_cnt;
   owner_t     last_owner;

   // Pick a winner; under contention the stream keeps the macros until its burst budget runs out.
   // A WB grant clears the budget, so the stream is favoured again right after the WB access.
   always_comb begin
      gnt_wb  = 1'b0;
      gnt_str = 1'b0;
      if (eval) begin
         if (wb_req && str_req) begin
            if ((last_owner == OWNER_WB) || (burst_cnt < BURST_MAX)) begin
               gnt_str = 1'b1;
            end else begin
               gnt_wb = 1'b1;
            end
         end else begin
            gnt_wb  = wb_req;
            gnt_str = str_req;
         end
      end
   end

   // Track the previous owner and how many stream grants have been made over a waiting WB master.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt  <= '0;
         last_owner <= OWNER_WB;
      end else if (gnt_wb) begin
         burst_cnt  <= '0;
         last_owner <= OWNER_WB;
      end else if (gnt_str) begin
         last_owner <= OWNER_STR;
         if (!wb_req) begin
            burst_cnt <= '0;
         end else if (burst_cnt < BURST_MAX) begin
            burst_cnt <= burst_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares two 512x32 SRAM macros between the Wishbone slave path and a read-only stream port.
// Latency: request accepted at edge k -> ack/rvalid high in the cycle after edge k+2 (1 access / 3 cycles).
// Backpressure: WB waits for ack, stream holds str_req until str_gnt; optional WB_MEM_ARB_STATS_EN adds stat_conflicts.
module wb_mem_arbiter
   import wb_mem_arb_pkg::*;
#(
   parameter int STREAM_BURST_MAX = 4,
   parameter int MEM_AW           = 9
) (
   input  logic              io_wbs_clk,
   input  logic              io_wbs_rst_n,
   input  logic [31:0]       io_wbs_adr,
   input  logic [DATA_W-1:0] io_wbs_datwr,
   output logic [DATA_W-1:0] io_wbs_datrd,
   input  logic              io_wbs_we,
   input  logic [SEL_W-1:0]  io_wbs_sel,
   input  logic              io_wbs_stb,
   input  logic              io_wbs_cyc,
   output logic              io_wbs_ack,
   input  logic              str_req,
   input  logic [MEM_AW:0]   str_addr,
   output logic              str_gnt,
   output logic              str_rvalid,
   output logic [DATA_W-1:0] str_rdata,
   output logic              csb_mem0,
   output logic              csb_mem1,
   output logic              web_mem0,
   output logic              web_mem1,
   output logic [SEL_W-1:0]  wmask_mem0,
   output logic [SEL_W-1:0]  wmask_mem1,
   output logic [MEM_AW-1:0] addr_mem0,
   output logic [MEM_AW-1:0] addr_mem1,
   output logic [DATA_W-1:0] din_mem0,
   output logic [DATA_W-1:0] din_mem1,
   input  logic [DATA_W-1:0] dout_mem0,
   input  logic [DATA_W-1:0] dout_mem1
`ifdef WB_MEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_conflicts
`endif
);

   arb_state_t state;
   owner_t     owner;
   logic       mem_sel;

   logic              wb_req;
   logic              gnt_wb;
   logic              gnt_str;
   logic              nxt_sel;
   logic              nxt_wr;
   logic [MEM_AW-1:0] nxt_addr;
   logic [SEL_W-1:0]  nxt_wmask;
   logic [DATA_W-1:0] nxt_din;
   logic              unused_adr;

   // Upper address bits alias; byte offset is implied by io_wbs_sel.
   assign unused_adr = ^{io_wbs_adr[31:MEM_AW+3], io_wbs_adr[1:0]};

   // The !ack term stops the still-high strobe from re-launching the access during its ack cycle.
   assign wb_req = io_wbs_cyc & io_wbs_stb & ~io_wbs_ack;

   wb_mem_arb_grant #(
      .STREAM_BURST_MAX (STREAM_BURST_MAX)
   ) u_grant (
      .clk     (io_wbs_clk),
      .rst_n   (io_wbs_rst_n),
      .eval    (state == IDLE),
      .wb_req  (wb_req),
      .str_req (str_req),
      .gnt_wb  (gnt_wb),
      .gnt_str (gnt_str)
   );

   // Build the macro command for whichever requester wins this cycle.
   always_comb begin
      nxt_sel   = gnt_str ? str_addr[MEM_AW] : io_wbs_adr[MEM_AW+2];
      nxt_addr  = gnt_str ? str_addr[MEM_AW-1:0] : io_wbs_adr[MEM_AW+1:2];
      nxt_wr    = gnt_wb & io_wbs_we;
      nxt_wmask = nxt_wr ? io_wbs_sel : '0;
      nxt_din   = gnt_wb ? io_wbs_datwr : '0;
   end

   // Access sequencer: IDLE launches, MEM holds the registered macro controls, RESP returns the data.
   always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
      if (!io_wbs_rst_n) begin
         state        <= IDLE;
         owner        <= OWNER_WB;
         mem_sel      <= 1'b0;
         csb_mem0     <= 1'b1;
         csb_mem1     <= 1'b1;
         web_mem0     <= 1'b1;
         web_mem1     <= 1'b1;
         wmask_mem0   <= '0;
         wmask_mem1   <= '0;
         addr_mem0    <= '0;
         addr_mem1    <= '0;
         din_mem0     <= '0;
         din_mem1     <= '0;
         io_wbs_ack   <= 1'b0;
         io_wbs_datrd <= '0;
         str_gnt      <= 1'b0;
         str_rvalid   <= 1'b0;
         str_rdata    <= '0;
      end else begin
         io_wbs_ack <= 1'b0;
         str_rvalid <= 1'b0;
         str_gnt    <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_wb || gnt_str) begin
                  state    <= MEM;
                  owner    <= gnt_str ? OWNER_STR : OWNER_WB;
                  mem_sel  <= nxt_sel;
                  str_gnt  <= gnt_str;
                  csb_mem0 <= nxt_sel;
                  csb_mem1 <= ~nxt_sel;
                  web_mem0 <= ~(nxt_wr & ~nxt_sel);
                  web_mem1 <= ~(nxt_wr & nxt_sel);
                  if (nxt_sel) begin
                     addr_mem1  <= nxt_addr;
                     wmask_mem1 <= nxt_wmask;
                     din_mem1   <= nxt_din;
                  end else begin
                     addr_mem0  <= nxt_addr;
                     wmask_mem0 <= nxt_wmask;
                     din_mem0   <= nxt_din;
                  end
               end
            end
            MEM: begin
               state    <= RESP;
               csb_mem0 <= 1'b1;
               csb_mem1 <= 1'b1;
               web_mem0 <= 1'b1;
               web_mem1 <= 1'b1;
            end
            RESP: begin
               state <= IDLE;
               if (owner == OWNER_WB) begin
                  io_wbs_datrd <= mem_sel ? dout_mem1 : dout_mem0;
                  io_wbs_ack   <= 1'b1;
               end else begin
                  str_rdata  <= mem_sel ? dout_mem1 : dout_mem0;
                  str_rvalid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_MEM_ARB_STATS_EN
   // Count IDLE cycles in which both sides compete, saturating.
   always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
      if (!io_wbs_rst_n) begin
         stat_conflicts <= '0;
      end else if ((state == IDLE) && wb_req && str_req && (stat_conflicts != 16'hFFFF)) begin
         stat_conflicts <= stat_conflicts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed cases plus randomized WB/stream traffic.
// Latency: expects ack/rvalid three edges after the accepting IDLE cycle begins.
// Backpressure: WB master waits for ack, stream master holds str_req until str_gnt.
module tb_wb_mem_arbiter;

   typedef struct packed {
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] io_wbs_adr, io_wbs_datwr, io_wbs_datrd;
   logic        io_wbs_we, io_wbs_stb, io_wbs_cyc, io_wbs_ack;
   logic [3:0]  io_wbs_sel;
   logic        str_req, str_gnt, str_rvalid;
   logic [9:0]  str_addr;
   logic [31:0] str_rdata;
   logic        csb_mem0, csb_mem1, web_mem0, web_mem1;
   logic [3:0]  wmask_mem0, wmask_mem1;
   logic [8:0]  addr_mem0, addr_mem1;
   logic [31:0] din_mem0, din_mem1, dout_mem0, dout_mem1;
`ifdef WB_MEM_ARB_STATS_EN
   logic [15:0] stat_conflicts;
`endif

   int   total = 0;
   int   bad   = 0;
   logic sb_en = 1'b1;
   logic log_en = 1'b0;

   exp_t exp_wb[$];
   exp_t exp_str[$];
   logic owner_log[$];

   logic [31:0] sram    [2][512];
   logic [31:0] ref_mem [2][512];

   always #5 clk = ~clk;

   wb_mem_arbiter dut (
      .io_wbs_clk   (clk),
      .io_wbs_rst_n (rst_n),
      .io_wbs_adr   (io_wbs_adr),
      .io_wbs_datwr (io_wbs_datwr),
      .io_wbs_datrd (io_wbs_datrd),
      .io_wbs_we    (io_wbs_we),
      .io_wbs_sel   (io_wbs_sel),
      .io_wbs_stb   (io_wbs_stb),
      .io_wbs_cyc   (io_wbs_cyc),
      .io_wbs_ack   (io_wbs_ack),
      .str_req      (str_req),
      .str_addr     (str_addr),
      .str_gnt      (str_gnt),
      .str_rvalid   (str_rvalid),
      .str_rdata    (str_rdata),
      .csb_mem0     (csb_mem0),
      .csb_mem1     (csb_mem1),
      .web_mem0     (web_mem0),
      .web_mem1     (web_mem1),
      .wmask_mem0   (wmask_mem0),
      .wmask_mem1   (wmask_mem1),
      .addr_mem0    (addr_mem0),
      .addr_mem1    (addr_mem1),
      .din_mem0     (din_mem0),
      .din_mem1     (din_mem1),
      .dout_mem0    (dout_mem0),
      .dout_mem1    (dout_mem1)
`ifdef WB_MEM_ARB_STATS_EN
      ,
      .stat_conflicts (stat_conflicts)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Behavioural SRAM macros: sample controls at the edge, read data appears the following cycle.
   always @(posedge clk) begin
      if (!csb_mem0) begin
         if (!web_mem0) begin
            for (int b = 0; b < 4; b++) if (wmask_mem0[b]) sram[0][addr_mem0][8*b +: 8] = din_mem0[8*b +: 8];
         end else dout_mem0 <= sram[0][addr_mem0];
      end
      if (!csb_mem1) begin
         if (!web_mem1) begin
            for (int b = 0; b < 4; b++) if (wmask_mem1[b]) sram[1][addr_mem1][8*b +: 8] = din_mem1[8*b +: 8];
         end else dout_mem1 <= sram[1][addr_mem1];
      end
   end

   // Scoreboard monitor: every response the DUT presents is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sb_en) begin
         if (io_wbs_ack) begin
            if (exp_wb.size() == 0) check("wb_unexpected_ack", 32'd1, 32'd0);
            else begin
               e = exp_wb.pop_front();
               if (e.chk) check("wb_rdata", io_wbs_datrd, e.dat);
            end
         end
         if (str_rvalid) begin
            if (exp_str.size() == 0) check("str_unexpected_rvalid", 32'd1, 32'd0);
            else begin
               e = exp_str.pop_front();
               check("str_rdata", str_rdata, e.dat);
            end
         end
      end
      if (log_en && rst_n && (!csb_mem0 || !csb_mem1)) owner_log.push_back(str_gnt);
   end

   // Reference memory: WB byte address [11] selects macro, [10:2] the word; stream addr [9] / [8:0].
   task automatic ref_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      for (int b = 0; b < 4; b++)
         if (sel[b]) ref_mem[adr[11]][adr[10:2]][8*b +: 8] = dat[8*b +: 8];
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
      exp_t e;
      logic got;
      e.chk = ~we;
      e.dat = ref_mem[adr[11]][adr[10:2]];
      if (we) ref_write(adr, dat, sel);
      exp_wb.push_back(e);
      io_wbs_adr = adr; io_wbs_we = we; io_wbs_datwr = dat; io_wbs_sel = sel;
      io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         if (io_wbs_ack) got = 1'b1;
      end
      if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0;
   endtask

   task automatic str_read(input logic [9:0] a);
      exp_t e;
      logic got;
      e.chk = 1'b1;
      e.dat = ref_mem[a[9]][a[8:0]];
      exp_str.push_back(e);
      str_addr = a; str_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         if (str_gnt) got = 1'b1;
      end
      if (!got) check("str_gnt_timeout", 32'd0, 32'd1);
      str_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csb_web"}, {28'd0, csb_mem0, csb_mem1, web_mem0, web_mem1}, 32'hF);
      check({tag, "_wmask_addr"}, {10'd0, wmask_mem0, wmask_mem1, addr_mem0, addr_mem1}, 32'd0);
      check({tag, "_din"}, din_mem0 | din_mem1, 32'd0);
      check({tag, "_flags"}, {29'd0, io_wbs_ack, str_gnt, str_rvalid}, 32'd0);
      check({tag, "_rdata"}, io_wbs_datrd | str_rdata, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic       seen;
      logic [5:0] exp_order;
      logic [31:0] r;
      logic [9:0] sa;

      for (int m = 0; m < 2; m++)
         for (int w = 0; w < 512; w++) begin
            sram[m][w] = 32'd0;
            ref_mem[m][w] = 32'd0;
         end
      dout_mem0 = '0; dout_mem1 = '0;
      io_wbs_adr = '0; io_wbs_datwr = '0; io_wbs_we = 1'b0; io_wbs_sel = '0;
      io_wbs_stb = 1'b0; io_wbs_cyc = 1'b0; str_req = 1'b0; str_addr = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Masked WB write to macro1 word 1, with MEM-cycle pin checks and 3-cycle ack.
      exp_wb.push_back('{chk: 1'b0, dat: 32'd0});
      ref_write(32'h0000_0804, 32'hDEADBEEF, 4'b0011);
      io_wbs_adr = 32'h0000_0804; io_wbs_we = 1'b1; io_wbs_datwr = 32'hDEADBEEF; io_wbs_sel = 4'b0011;
      io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1;
      @(posedge clk); #1;
      check("wr_mem_csb_web", {29'd0, csb_mem0, csb_mem1, web_mem1}, 32'b100);
      check("wr_mem_addr1", {23'd0, addr_mem1}, 32'd1);
      check("wr_mem_wmask1", {28'd0, wmask_mem1}, 32'b0011);
      check("wr_mem_din1", din_mem1, 32'hDEADBEEF);
      check("wr_mem_ack_early", {31'd0, io_wbs_ack}, 32'd0);
      @(posedge clk); #1;
      check("wr_resp_ack_early", {31'd0, io_wbs_ack}, 32'd0);
      @(posedge clk); #1;
      check("wr_ack_latency", {31'd0, io_wbs_ack}, 32'd1);
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0;
      @(posedge clk); #1;

      // Single read with stb still high through the ack cycle: one ack, no relaunch.
      exp_wb.push_back('{chk: 1'b1, dat: 32'h0000BEEF});
      io_wbs_adr = 32'h0000_0804; io_wbs_we = 1'b0; io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("rd_ack_high", {31'd0, io_wbs_ack}, 32'd1);
      @(posedge clk); #1;
      check("rd_ack_one_cycle", {31'd0, io_wbs_ack}, 32'd0);
      check("rd_no_relaunch", {30'd0, csb_mem0, csb_mem1}, 32'b11);
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0;
      @(posedge clk); #1;

      // Stream read of macro0 word 5.
      wb_xfer(32'h0000_0014, 1'b1, 32'h12345678, 4'hF);
      exp_str.push_back('{chk: 1'b1, dat: 32'h12345678});
      str_addr = 10'h005; str_req = 1'b1;
      @(posedge clk); #1;
      check("str_gnt_in_mem", {30'd0, str_gnt, csb_mem0}, 32'b10);
      str_req = 1'b0; str_addr = 10'h3FF;
      @(posedge clk); #1;
      check("str_rvalid_early", {30'd0, str_rvalid, io_wbs_ack}, 32'd0);
      @(posedge clk); #1;
      check("str_rvalid", {30'd0, str_rvalid, io_wbs_ack}, 32'b10);
      check("str_rdata_direct", str_rdata, 32'h12345678);
      @(posedge clk); #1;

      // Reset during the MEM cycle of a WB read aborts it.
      io_wbs_adr = 32'h0000_0014; io_wbs_we = 1'b0; io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1;
      @(posedge clk); #1;
      check("abort_in_mem", {31'd0, csb_mem0}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (io_wbs_ack) seen = 1'b1; end
      check("abort_no_ack", {31'd0, seen}, 32'd0);
      wb_xfer(32'hABCD_E014, 1'b0, 32'd0, 4'hF);
      @(posedge clk); #1;

      // Both sides held continuously from reset: four stream grants, then WB, then stream.
      sb_en = 1'b0;
      do_reset();
      owner_log.delete();
      log_en = 1'b1;
      io_wbs_adr = 32'h0000_0014; io_wbs_we = 1'b0; io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1;
      str_addr = 10'h005; str_req = 1'b1;
      for (int i = 0; i < 60 && owner_log.size() < 6; i++) @(posedge clk);
      #1;
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0; str_req = 1'b0;
      log_en = 1'b0;
      exp_order = 6'b101111;
      for (int i = 0; i < 6; i++) begin
         if (i < owner_log.size()) check($sformatf("arb_order_%0d", i), {31'd0, owner_log[i]}, {31'd0, exp_order[i]});
         else check($sformatf("arb_order_%0d_missing", i), 32'd0, 32'd1);
      end
      repeat (6) @(posedge clk);
      #1;
      sb_en = 1'b1;

`ifdef WB_MEM_ARB_STATS_EN
      sb_en = 1'b0;
      do_reset();
      check("stat_reset", {16'd0, stat_conflicts}, 32'd0);
      io_wbs_cyc = 1'b1; io_wbs_stb = 1'b1; str_req = 1'b1;
      begin
         int n;
         n = 0;
         for (int i = 0; i < 60 && n < 5; i++) begin
            @(posedge clk); #1;
            if (!csb_mem0 || !csb_mem1) n++;
         end
      end
      io_wbs_cyc = 1'b0; io_wbs_stb = 1'b0; str_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("stat_conflicts_5", {16'd0, stat_conflicts}, 32'd5);
      sb_en = 1'b1;
`endif

      // Preload the stream-readable region (words 0..63 of each macro).
      for (int m = 0; m < 2; m++)
         for (int w = 0; w < 64; w++)
            wb_xfer({20'd0, m[0], w[8:0], 2'b00}, 1'b1, $urandom(), 4'hF);

      // Concurrent random traffic; WB writes stay above word 63 so stream reads are order-independent.
      fork
         begin
            for (int t = 0; t < 60; t++) begin
               logic m;
               logic [8:0] w;
               logic we;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               r  = $urandom();
               m  = r[0];
               we = r[1];
               w  = we ? 9'($urandom_range(64, 511)) : 9'($urandom_range(0, 511));
               wb_xfer({r[31:12], m, w, 2'b00}, we, $urandom(), 4'($urandom_range(0, 15)));
            end
         end
         begin
            for (int t = 0; t < 60; t++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               sa = {1'($urandom_range(0, 1)), 9'($urandom_range(0, 63))};
               str_read(sa);
            end
         end
      join

      for (int i = 0; i < 20 && (exp_wb.size() + exp_str.size()) != 0; i++) @(posedge clk);
      @(negedge clk);
      check("sb_drain", exp_wb.size() + exp_str.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
